if_id_pipe_reg: RTL
===================

Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline register, successor to the fixed 32-bit two-cycle-flush stage register. Carries PC, instruction and branch-immediate fields from fetch to decode and adds:
- a valid bit
- a programmable-length flush
- a selectable stall mode
- saturating stall/flush event counters for the CGRA/RISC-V performance monitor.
Sits between the fetch unit (PC and instruction memory) and the decode/hazard logic.

Parameters:
PC_W, 32, width of pc_i/pc_o
INST_W, 32, width of inst_i/inst_o
IM_W, 12, width of pcIm_i/pcIm_o
FLUSH_CYCLES, 2, bubble cycles per flush request; legal range 1..15
BUBBLE_INST, 0, value driven on inst_o during a flush (INST_W bits)
STALL_HOLD_ALL, 0, 0: PC and imm keep following inputs on stall (legacy); 1: every field holds
PERF_W, 16, width of each saturating event counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
start_i  in  1  pipeline enable; low = synchronous clear
pc_i  in  PC_W  fetch PC
inst_i  in  INST_W  fetched instruction
pcIm_i  in  IM_W  branch immediate from fetch
valid_i  in  1  fetch output valid
hazard_i  in  1  stall request from hazard unit
flush_i  in  1  flush request (taken branch/jump)
pc_o  out  PC_W  registered PC
inst_o  out  INST_W  registered instruction
pcIm_o  out  IM_W  registered immediate
valid_o  out  1  registered valid; 0 on a bubble
flushing_o  out  1  flush sequence in progress (remaining count > 0)
stall_cnt_o  out  PERF_W  stall cycles taken, saturating
flush_cnt_o  out  PERF_W  flush requests accepted, saturating

Behaviour:
- Reset (rst_i=1, async):
  - all outputs 0; inst_o = 0, not BUBBLE_INST
  - internal flush counter (CNT_W = clog2(FLUSH_CYCLES+1) bits) = 0
- Per clock edge, when rst_i=0, the first matching rule applies:
  1. start_i=0: same values as reset, applied synchronously.
  2. flush_i=1:
     - pc_o <= pc_i, inst_o <= BUBBLE_INST, pcIm_o <= 0, valid_o <= 0
     - counter <= FLUSH_CYCLES-1
     - flush_cnt_o increments
     - a flush_i arriving while a sequence is running restarts the count
  3. counter>0:
     - outputs as in rule 2
     - counter decrements
     - flush_cnt_o unchanged
  4. hazard_i=1:
     - inst_o and valid_o hold
     - pc_o/pcIm_o load inputs if STALL_HOLD_ALL=0, hold if STALL_HOLD_ALL=1
     - stall_cnt_o increments
  5. Otherwise: pc_o, inst_o, pcIm_o, valid_o <= pc_i, inst_i, pcIm_i, valid_i.
- Timing:
  - latency is 1 cycle input to output
  - total bubble length per isolated flush = FLUSH_CYCLES (FLUSH_CYCLES=1: no counting phase)
  - flushing_o is combinational from the counter; it is high for FLUSH_CYCLES-1 cycles after the flush edge.
- Simultaneous events:
  - flush beats hazard; a hazard during a flush is not counted
  - start_i=0 beats flush
- Counters:
  - saturate at 2^PERF_W-1 with no wrap
  - cleared only by reset or start_i=0
- Reset asserted mid-flush: the counter clears immediately; no residual bubbles after release.
- FLUSH_CYCLES outside 1..15: elaboration error via generate-time check.

Decomposition:
- Shared package pipe_pkg holds:
  - default widths PC_W/INST_W/IM_W
  - NOP encoding constant (for BUBBLE_INST overrides)
  - flush priority encoding (localparam codes for the five rules)
- One sub-module is natural: sat_counter (parameter W, inc, clr, async rst, saturating). Instantiate it twice.
- The flush countdown stays inline.

Test Plan:
1. Reset and enable: rst_i pulse, then start_i=1, valid_i=1, pc_i=0x100, inst_i=0x00500093. Required: all outputs 0 during reset; next edge pc_o=0x100, inst_o=0x00500093, valid_o=1.
2. Default flush: flush_i for 1 cycle with FLUSH_CYCLES=2. Required: inst_o=0 and valid_o=0 for exactly 2 edges, flushing_o high 1 cycle, flush_cnt_o=1, then normal capture resumes.
3. Flush restart and long flush: FLUSH_CYCLES=4, flush_i at cycle 0 and again at cycle 2. Required: bubbles on cycles 0..5 (6 total), flush_cnt_o=2.
4. Stall modes:
   - hazard_i for 3 cycles with pc_i stepping 0x200, 0x204, 0x208.
   - STALL_HOLD_ALL=0: inst_o held, pc_o follows to 0x208.
   - STALL_HOLD_ALL=1: pc_o held at its pre-stall value.
   - Both modes: stall_cnt_o=3.
5. Priority: flush_i and hazard_i together for 1 cycle. Required: bubble, stall_cnt_o unchanged; start_i=0 in the same cycle instead clears everything.
6. Saturation and mid-flush reset:
   - PERF_W=2, 5 stall cycles. Required: stall_cnt_o=3.
   - rst_i asserted during counting, then released. Required: no bubble after release, flushing_o=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, NOP encoding and update-rule codes for the IF/ID stage register.
package pipe_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;
  localparam int IM_W_DEF   = 12;

  // RV32I "addi x0, x0, 0"; handy as a BUBBLE_INST override
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Update rules in priority order, highest first
  localparam logic [2:0] RULE_CLEAR = 3'd0;
  localparam logic [2:0] RULE_FLUSH = 3'd1;
  localparam logic [2:0] RULE_DRAIN = 3'd2;
  localparam logic [2:0] RULE_STALL = 3'd3;
  localparam logic [2:0] RULE_PASS  = 3'd4;

endpackage

// File: rtl/if_id_pipe_reg_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid bit, programmable-length flush,
// selectable stall behaviour and saturating stall/flush event counters.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int                PC_W           = PC_W_DEF,
  parameter int                INST_W         = INST_W_DEF,
  parameter int                IM_W           = IM_W_DEF,
  parameter int                FLUSH_CYCLES   = 2,
  parameter logic [INST_W-1:0] BUBBLE_INST    = '0,
  parameter bit                STALL_HOLD_ALL = 1'b0,
  parameter int                PERF_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [IM_W-1:0]   pcIm_i,
  input  logic              valid_i,
  input  logic              hazard_i,
  input  logic              flush_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [IM_W-1:0]   pcIm_o,
  output logic              valid_o,
  output logic              flushing_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15)) begin : g_bad_flush_cycles
    $error("if_id_pipe_reg: FLUSH_CYCLES must be within 1..15");
  end

  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;
  logic [IM_W-1:0]   r_pcim;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        w_rule;
  logic [PERF_W-1:0] w_stall_cnt;
  logic [PERF_W-1:0] w_flush_cnt;

  always_comb begin
    w_rule = RULE_PASS;
    if (!start_i)             w_rule = RULE_CLEAR;
    else if (flush_i)         w_rule = RULE_FLUSH;
    else if (r_cnt != '0)     w_rule = RULE_DRAIN;
    else if (hazard_i)        w_rule = RULE_STALL;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc    <= '0;
      r_inst  <= '0;
      r_pcim  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (w_rule)
        RULE_CLEAR: begin
          r_pc    <= '0;
          r_inst  <= '0;
          r_pcim  <= '0;
          r_valid <= 1'b0;
          r_cnt   <= '0;
        end
        RULE_FLUSH, RULE_DRAIN: begin
          // PC keeps tracking fetch so decode sees where the redirect landed
          r_pc    <= pc_i;
          r_inst  <= BUBBLE_INST;
          r_pcim  <= '0;
          r_valid <= 1'b0;
          r_cnt   <= (w_rule == RULE_FLUSH) ? FLUSH_LOAD : r_cnt - CNT_W'(1);
        end
        RULE_STALL: begin
          if (!STALL_HOLD_ALL) begin
            r_pc   <= pc_i;
            r_pcim <= pcIm_i;
          end
        end
        default: begin
          r_pc    <= pc_i;
          r_inst  <= inst_i;
          r_pcim  <= pcIm_i;
          r_valid <= valid_i;
        end
      endcase
    end
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_rule == RULE_CLEAR),
    .inc_i (w_rule == RULE_STALL),
    .cnt_o (w_stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_rule == RULE_CLEAR),
    .inc_i (w_rule == RULE_FLUSH),
    .cnt_o (w_flush_cnt)
  );

  assign pc_o        = r_pc;
  assign inst_o      = r_inst;
  assign pcIm_o      = r_pcim;
  assign valid_o     = r_valid;
  assign flushing_o  = (r_cnt != '0);
  assign stall_cnt_o = w_stall_cnt;
  assign flush_cnt_o = w_flush_cnt;

endmodule
